// File: rtl/rob_retire.sv
// 8-entry reorder buffer: allocates at the tail, completes from the CDB and
// retires one completed entry per cycle from the head; a mispredicted branch flushes.

module rob_entry #(
  parameter int DATA_W = 16
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              alloc_i,
  input  logic [3:0]        func_i,
  input  logic [3:0]        rd_i,
  input  logic              cdb_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              retire_i,
  input  logic              flush_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [3:0]        func_o,
  output logic [3:0]        rd_o,
  output logic [DATA_W-1:0] data_o
);
  logic              busy_q, done_q;
  logic [3:0]        func_q, rd_q;
  logic [DATA_W-1:0] data_q;

  // Flush wins over everything, which also drops any same-cycle CDB write.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      func_q <= '0;
      rd_q   <= '0;
      data_q <= '0;
    end else if (flush_i) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      if (retire_i) begin
        busy_q <= 1'b0;
        done_q <= 1'b0;
      end
      if (alloc_i) begin
        busy_q <= 1'b1;
        done_q <= 1'b0;
        func_q <= func_i;
        rd_q   <= rd_i;
      end
      if (cdb_i) begin
        done_q <= 1'b1;
        data_q <= data_i;
      end
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign func_o = func_q;
  assign rd_o   = rd_q;
  assign data_o = data_q;
endmodule

module rob_retire #(
  parameter int         DEPTH   = 8,
  parameter int         IDX_W   = 3,
  parameter int         DATA_W  = 16,
  parameter logic [3:0] BR_FUNC = 4'hF
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              alloc_valid,
  input  logic [3:0]        alloc_func,
  input  logic [3:0]        alloc_rd,
  output logic              alloc_ready,
  output logic [IDX_W-1:0]  alloc_idx,
  input  logic              cdb_valid,
  input  logic [IDX_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  output logic              commit_valid,
  output logic [3:0]        commit_rd,
  output logic [DATA_W-1:0] commit_data,
  output logic [IDX_W-1:0]  commit_tag,
  output logic [3:0]        commit_func,
  output logic              flush,
  output logic [IDX_W-1:0]  head_p,
  output logic [IDX_W-1:0]  tail_p,
  output logic [IDX_W:0]    count
);
  localparam logic [IDX_W:0] FULL = (IDX_W+1)'(DEPTH);

  logic [DEPTH-1:0]             busy, done;
  logic [DEPTH-1:0][3:0]        func, rd;
  logic [DEPTH-1:0][DATA_W-1:0] data;

  logic [IDX_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [IDX_W:0]    count_q, count_d;
  logic              cv_q, flush_q;
  logic [3:0]        crd_q, crd_d, cfunc_q, cfunc_d;
  logic [DATA_W-1:0] cdata_q, cdata_d;
  logic [IDX_W-1:0]  ctag_q, ctag_d;

  logic retire_ok, mispred, do_alloc;

  assign retire_ok   = busy[head_q] & done[head_q];
  assign mispred     = retire_ok & (func[head_q] == BR_FUNC) & data[head_q][0];
  assign alloc_ready = (count_q < FULL) & !mispred;
  assign alloc_idx   = tail_q;
  assign do_alloc    = alloc_valid & alloc_ready;

  genvar g;
  generate
    for (g = 0; g < DEPTH; g++) begin : g_ent
      logic sel_tail, sel_cdb, sel_head;
      assign sel_tail = do_alloc & (tail_q == IDX_W'(g));
      assign sel_cdb  = cdb_valid & (cdb_tag == IDX_W'(g)) & busy[g] & !done[g] & !mispred;
      assign sel_head = retire_ok & (head_q == IDX_W'(g));
      rob_entry #(.DATA_W(DATA_W)) u_ent (
        .clk1     (clk1),
        .rst_n    (rst_n),
        .alloc_i  (sel_tail),
        .func_i   (alloc_func),
        .rd_i     (alloc_rd),
        .cdb_i    (sel_cdb),
        .data_i   (cdb_data),
        .retire_i (sel_head),
        .flush_i  (mispred),
        .busy_o   (busy[g]),
        .done_o   (done[g]),
        .func_o   (func[g]),
        .rd_o     (rd[g]),
        .data_o   (data[g])
      );
    end
  endgenerate

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    crd_d   = crd_q;
    cdata_d = cdata_q;
    ctag_d  = ctag_q;
    cfunc_d = cfunc_q;
    if (retire_ok) begin
      crd_d   = rd[head_q];
      cdata_d = data[head_q];
      ctag_d  = head_q;
      cfunc_d = func[head_q];
      head_d  = head_q + IDX_W'(1);
    end
    if (do_alloc) tail_d = tail_q + IDX_W'(1);
    count_d = count_q + {{IDX_W{1'b0}}, do_alloc} - {{IDX_W{1'b0}}, retire_ok};
    // Flush restarts an empty ROB right after the branch.
    if (mispred) begin
      tail_d  = head_q + IDX_W'(1);
      count_d = '0;
    end
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      cv_q    <= 1'b0;
      flush_q <= 1'b0;
      crd_q   <= '0;
      cdata_q <= '0;
      ctag_q  <= '0;
      cfunc_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      cv_q    <= retire_ok;
      flush_q <= mispred;
      crd_q   <= crd_d;
      cdata_q <= cdata_d;
      ctag_q  <= ctag_d;
      cfunc_q <= cfunc_d;
    end
  end

  assign commit_valid = cv_q;
  assign flush        = flush_q;
  assign commit_rd    = crd_q;
  assign commit_data  = cdata_q;
  assign commit_tag   = ctag_q;
  assign commit_func  = cfunc_q;
  assign head_p       = head_q;
  assign tail_p       = tail_q;
  assign count        = count_q;
endmodule

// File: tb/tb_rob_retire.sv
// Bench for rob_retire: vector table, directed corner sequences and random
// traffic against an in-order queue model of the ROB.

module tb_rob_retire;
  logic        clk1 = 1'b0;
  logic        rst_n;
  logic        alloc_valid;
  logic [3:0]  alloc_func, alloc_rd;
  logic        alloc_ready;
  logic [2:0]  alloc_idx;
  logic        cdb_valid;
  logic [2:0]  cdb_tag;
  logic [15:0] cdb_data;
  logic        commit_valid;
  logic [3:0]  commit_rd, commit_func;
  logic [15:0] commit_data;
  logic [2:0]  commit_tag;
  logic        flush;
  logic [2:0]  head_p, tail_p;
  logic [3:0]  count;

  rob_retire dut (
    .clk1(clk1), .rst_n(rst_n),
    .alloc_valid(alloc_valid), .alloc_func(alloc_func), .alloc_rd(alloc_rd),
    .alloc_ready(alloc_ready), .alloc_idx(alloc_idx),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_data(commit_data),
    .commit_tag(commit_tag), .commit_func(commit_func), .flush(flush),
    .head_p(head_p), .tail_p(tail_p), .count(count)
  );

  always #5 clk1 = ~clk1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Model: the ROB is simply a program-ordered queue of live entries.
  typedef struct {
    int         tag;
    logic [3:0] func;
    logic [3:0] rd;
    logic       done;
    logic [15:0] data;
  } ent_t;
  ent_t q[$];
  int m_head, m_tail;
  logic e_cv, e_fl;
  logic [3:0] e_rd, e_func;
  logic [15:0] e_data;
  logic [2:0] e_tag;

  function automatic logic m_mis();
    return q.size() > 0 && q[0].done && q[0].func == 4'hF && q[0].data[0];
  endfunction

  task automatic m_reset();
    q.delete();
    m_head = 0; m_tail = 0;
    e_cv = 0; e_fl = 0; e_rd = 0; e_func = 0; e_data = 0; e_tag = 0;
  endtask

  task automatic m_step(input logic av, input logic [3:0] f, input logic [3:0] r,
                        input logic cv, input logic [2:0] ct, input logic [15:0] cd);
    logic ret, mis, acc;
    ent_t n;
    ret = q.size() > 0 && q[0].done;
    mis = m_mis();
    acc = av && q.size() < 8 && !mis;
    if (cv && !mis)
      foreach (q[i]) if (q[i].tag == int'(ct) && !q[i].done) begin
        q[i].done = 1; q[i].data = cd;
      end
    e_cv = ret; e_fl = mis;
    if (ret) begin
      e_rd = q[0].rd; e_func = q[0].func; e_data = q[0].data; e_tag = 3'(q[0].tag);
      void'(q.pop_front());
      m_head = (m_head + 1) % 8;
    end
    if (mis) begin
      q.delete();
      m_tail = m_head;
    end
    if (acc) begin
      n.tag = m_tail; n.func = f; n.rd = r; n.done = 0; n.data = 0;
      q.push_back(n);
      m_tail = (m_tail + 1) % 8;
    end
  endtask

  // One clock: drive, check combinational outputs, clock, check registered state.
  task automatic cyc(input logic av, input logic [3:0] f, input logic [3:0] r,
                     input logic cv, input logic [2:0] ct, input logic [15:0] cd);
    alloc_valid = av; alloc_func = f; alloc_rd = r;
    cdb_valid = cv; cdb_tag = ct; cdb_data = cd;
    #2;
    chk("alloc_ready", alloc_ready, (q.size() < 8) && !m_mis());
    chk("alloc_idx", alloc_idx, m_tail);
    m_step(av, f, r, cv, ct, cd);
    @(posedge clk1); #1;
    chk("commit_valid", commit_valid, e_cv);
    chk("flush", flush, e_fl);
    chk("commit_rd", commit_rd, e_rd);
    chk("commit_data", commit_data, e_data);
    chk("commit_tag", commit_tag, e_tag);
    chk("commit_func", commit_func, e_func);
    chk("head_p", head_p, m_head);
    chk("tail_p", tail_p, m_tail);
    chk("count", count, q.size());
    alloc_valid = 0; cdb_valid = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst_n = 0;
    alloc_valid = 0; alloc_func = 0; alloc_rd = 0;
    cdb_valid = 0; cdb_tag = 0; cdb_data = 0;
    m_reset();
    #12;
    @(negedge clk1);
    rst_n = 1;
  endtask

  typedef struct {
    logic av; logic [3:0] f; logic [3:0] rd;
    logic cv; logic [2:0] tag; logic [15:0] d;
    logic ecv; logic [3:0] erd; logic [15:0] ed; logic [2:0] etag; logic [3:0] ecnt;
  } vec_t;
  vec_t tbl[10];

  initial begin
    // In-order retire with out-of-order completion.
    tbl[0] = '{1, 4'h1, 4'd3, 0, 3'd0, 16'h0000, 0, 4'd0, 16'h0000, 3'd0, 4'd1};
    tbl[1] = '{1, 4'h1, 4'd4, 0, 3'd0, 16'h0000, 0, 4'd0, 16'h0000, 3'd0, 4'd2};
    tbl[2] = '{1, 4'h1, 4'd5, 0, 3'd0, 16'h0000, 0, 4'd0, 16'h0000, 3'd0, 4'd3};
    tbl[3] = '{0, 4'h0, 4'd0, 1, 3'd2, 16'h0022, 0, 4'd0, 16'h0000, 3'd0, 4'd3};
    tbl[4] = '{0, 4'h0, 4'd0, 1, 3'd0, 16'h0011, 0, 4'd0, 16'h0000, 3'd0, 4'd3};
    tbl[5] = '{0, 4'h0, 4'd0, 0, 3'd0, 16'h0000, 1, 4'd3, 16'h0011, 3'd0, 4'd2};
    tbl[6] = '{0, 4'h0, 4'd0, 1, 3'd1, 16'h0033, 0, 4'd3, 16'h0011, 3'd0, 4'd2};
    tbl[7] = '{0, 4'h0, 4'd0, 0, 3'd0, 16'h0000, 1, 4'd4, 16'h0033, 3'd1, 4'd1};
    tbl[8] = '{0, 4'h0, 4'd0, 0, 3'd0, 16'h0000, 1, 4'd5, 16'h0022, 3'd2, 4'd0};
    tbl[9] = '{0, 4'h0, 4'd0, 0, 3'd0, 16'h0000, 0, 4'd5, 16'h0022, 3'd2, 4'd0};

    // Reset / empty
    do_reset();
    #1;
    chk("rst alloc_ready", alloc_ready, 1);
    chk("rst count", count, 0);
    chk("rst head", head_p, 0);
    chk("rst tail", tail_p, 0);
    chk("rst commit_valid", commit_valid, 0);
    for (int i = 0; i < 10; i++) begin
      cyc(0, 0, 0, 0, 0, 0);
      chk("idle commit_valid", commit_valid, 0);
    end

    // Table vectors
    for (int i = 0; i < 10; i++) begin
      cyc(tbl[i].av, tbl[i].f, tbl[i].rd, tbl[i].cv, tbl[i].tag, tbl[i].d);
      chk($sformatf("tbl%0d commit_valid", i), commit_valid, tbl[i].ecv);
      chk($sformatf("tbl%0d commit_rd", i), commit_rd, tbl[i].erd);
      chk($sformatf("tbl%0d commit_data", i), commit_data, tbl[i].ed);
      chk($sformatf("tbl%0d commit_tag", i), commit_tag, tbl[i].etag);
      chk($sformatf("tbl%0d count", i), count, tbl[i].ecnt);
    end

    // Full and wrap
    do_reset();
    for (int i = 0; i < 8; i++) cyc(1, 4'h2, 4'(i), 0, 0, 0);
    chk("full count", count, 8);
    chk("full tail wrap", tail_p, 0);
    #1 chk("full alloc_ready", alloc_ready, 0);
    cyc(1, 4'h2, 4'd9, 0, 0, 0);
    chk("9th ignored count", count, 8);
    cyc(0, 0, 0, 1, 3'd0, 16'hA5A5);
    chk("full still", count, 8);
    cyc(0, 0, 0, 0, 0, 0);
    chk("full commit tag0", commit_valid & (commit_tag == 0), 1);
    chk("after commit count", count, 7);
    #1 chk("wrap alloc_idx", alloc_idx, 0);
    cyc(1, 4'h2, 4'd7, 0, 0, 0);
    chk("wrap tail", tail_p, 1);
    chk("wrap count", count, 8);

    // Simultaneous alloc and commit
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1, 4'h1, 4'(i), 0, 0, 0);
    cyc(0, 0, 0, 1, 3'd0, 16'h1234);
    cyc(1, 4'h1, 4'd8, 0, 0, 0);
    chk("simul commit", commit_valid, 1);
    chk("simul count", count, 4);
    chk("simul head", head_p, 1);
    chk("simul tail", tail_p, 5);

    // Mispredicted branch flush
    do_reset();
    cyc(1, 4'h1, 4'd1, 0, 0, 0);
    cyc(1, 4'hF, 4'd2, 0, 0, 0);
    cyc(1, 4'h1, 4'd3, 0, 0, 0);
    cyc(1, 4'h1, 4'd4, 0, 0, 0);
    cyc(0, 0, 0, 1, 3'd0, 16'h0005);
    cyc(0, 0, 0, 1, 3'd1, 16'h0001);
    chk("br tag0 commit", commit_valid & (commit_tag == 0) & !flush, 1);
    cyc(0, 0, 0, 1, 3'd2, 16'h0007);
    chk("br flush", flush, 1);
    chk("br commit_valid", commit_valid, 1);
    chk("br commit_tag", commit_tag, 1);
    chk("br count", count, 0);
    chk("br head", head_p, 2);
    chk("br tail", tail_p, 2);
    cyc(0, 0, 0, 1, 3'd3, 16'h0009);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 0, 0, 0);
      chk("post-flush no commit", commit_valid, 0);
    end

    // Async reset mid-stream
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1, 4'h1, 4'(i), 0, 0, 0);
    cyc(0, 0, 0, 1, 3'd0, 16'hBEEF);
    chk("pre-rst count", count, 5);
    #3 rst_n = 0;
    #1;
    chk("arst count", count, 0);
    chk("arst head", head_p, 0);
    chk("arst tail", tail_p, 0);
    chk("arst commit_valid", commit_valid, 0);
    chk("arst flush", flush, 0);
    chk("arst commit_rd", commit_rd, 0);
    chk("arst commit_data", commit_data, 0);
    @(posedge clk1); #1;
    chk("arst no pulse", commit_valid, 0);
    @(negedge clk1);
    rst_n = 1;
    m_reset();
    idle(3);

    // Random traffic against the queue model
    for (int n = 0; n < 3000; n++) begin
      logic av, cv;
      logic [3:0] f;
      logic [2:0] t;
      av = ($urandom_range(0, 9) < 6);
      f  = ($urandom_range(0, 4) == 0) ? 4'hF : 4'($urandom_range(0, 14));
      cv = ($urandom_range(0, 9) < 7);
      t  = 3'($urandom_range(0, 7));
      if (q.size() > 0 && $urandom_range(0, 4) != 0) t = 3'(q[$urandom_range(0, q.size() - 1)].tag);
      cyc(av, f, 4'($urandom), cv, t, 16'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
